mac_channel_acc: RTL and testbench
==================================

# mac_channel_acc

Sequential, parametrised multiply-accumulate engine for the convolution datapath. It takes one K×K feature window and one K×K kernel per input channel over a valid/ready handshake. Each dot product is computed over several cycles using `LANES` multipliers. Results are accumulated across a runtime-selected number of input channels, with an optional bias and ReLU. It sits between the window/line-buffer stage and the output writeback stage, and replaces single-shot combinational MAC instances where multiplier count must be traded against throughput.

## Interface
- `KERNEL_SIZE`, default 5: window/kernel side K; the engine processes K*K products per channel.
- `DATA_WIDTH`, default 8: signed width of feature and kernel elements.
- `LANES`, default 5: multipliers per cycle, with 1 ≤ LANES ≤ K*K.
- `MAX_CHANNELS`, default 16: maximum input channels accumulated into one result.
- Derived: NUM_PRODUCTS = K*K; BEATS = ceil(NUM_PRODUCTS/LANES); ACC_WIDTH = 2*DATA_WIDTH + $clog2(NUM_PRODUCTS) + $clog2(MAX_CHANNELS); CH_W = $clog2(MAX_CHANNELS+1).
- Clocking: one clock; reset is synchronous and active-high.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: a channel's feature and kernel are present.
- `in_ready`  out  1: the engine can accept a channel.
- `feature`  in  signed [DATA_WIDTH-1:0] [0:K-1][0:K-1]: feature window.
- `kernel`  in  signed [DATA_WIDTH-1:0] [0:K-1][0:K-1]: kernel weights.
- `num_channels`  in  CH_W: channels per result; sampled at the first channel only.
- `bias`  in  signed [2*DATA_WIDTH-1:0]: sign-extended bias; sampled at the first channel only.
- `relu_en`  in  1: clamp negative results to 0; sampled at the first channel only.
- `out_valid`  out  1: `result` is valid.
- `out_ready`  in  1: downstream accepts `result`.
- `result`  out  signed [ACC_WIDTH-1:0]: final accumulated value.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MAC: `in_ready`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- IDLE transition: an accept is `in_valid` && `in_ready`. On accept, latch `feature` and `kernel`, clear the beat counter and enter MAC.
- First-channel setup: when the channel counter `ch_cnt` is 0 at an accept:
  - load acc with sign-extended `bias`;
  - latch `num_channels`, treating 0 as 1 and clamping values above MAX_CHANNELS to MAX_CHANNELS;
  - latch `relu_en`.
- Later channels: acc keeps its value.
- MAC beat b (0..BEATS-1): acc += sum of products p = b*LANES .. b*LANES+LANES-1.
  - Products use row-major index p = i*K + j.
  - Product indices ≥ NUM_PRODUCTS contribute 0 (padding lanes).
- Arithmetic: products are full 2*DATA_WIDTH signed; all sums are signed at ACC_WIDTH. The widths are sized so no overflow or saturation occurs within the parameter limits.
- After beat BEATS-1:
  - if `ch_cnt` == latched channels-1, go to DONE;
  - else increment `ch_cnt` and return to IDLE.
- DONE: `result` = (relu && acc<0) ? 0 : acc, held stable while `out_ready`=0. On `out_valid` && `out_ready`: clear `ch_cnt` and go to IDLE.
- Reset at any time: any in-flight accumulation is abandoned, with no partial output.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, acc=0, `ch_cnt`=0.
- `in_ready` and `out_valid` are decoded from registered state only; there are no combinational paths from `in_valid` or `out_ready` to outputs.
- Latency: a channel accepted at edge E0 has its beats applied at edges E1..E_BEATS. After the final channel, `out_valid` is high in the cycle following E_BEATS.
- Channel throughput: one channel per BEATS+1 cycles. The extra cycle is the IDLE accept cycle; defaults give 6 cycles per channel.
- Single-channel result: `out_valid` rises BEATS cycles after the accept edge (5 at defaults). With LANES=4 and K=5, BEATS=7.
- Output handshake: the result handshake completes at the edge where `out_valid` && `out_ready`. `in_ready` is 1 in the following cycle, so the earliest next accept is one cycle after the output handshake.
- Input stability: `feature` and `kernel` may change after the accept edge, since the engine has latched them. `in_valid` asserted during MAC or DONE is ignored.

## Test plan
- Ones: defaults, feature=1 and kernel=1 everywhere, num_channels=1, bias=0 -> `out_valid` 5 cycles after the accept edge, `result`=25.
- Extremes: feature=-128, kernel=-128 everywhere, 1 channel -> `result`=409600. Then kernel=127 -> `result`=-406400.
- Multi-channel with bias: 3 channels of feature=2, kernel=3, bias=-50 -> `result`=400.
  - `in_ready` must be low in MAC and high in exactly one idle slot between channels.
  - `num_channels` and `bias` changed after the first accept have no effect.
- ReLU: feature=1, kernel=-1, bias=0:
  - `relu_en`=0 -> `result`=-25;
  - `relu_en`=1 -> `result`=0.
- Backpressure and boundaries:
  - Hold `out_ready`=0 for 10 cycles -> `result` stable, `in_ready`=0 and `in_valid` ignored; then accepted in 1 cycle.
  - `num_channels`=0 behaves as 1.
  - LANES=4 build, ones test -> `result`=25 at 7 cycles.
- Reset mid-MAC: assert `rst` at beat 2 of channel 1 of 3 -> all outputs at reset values. A fresh single-channel ones operation then yields `result`=25 with no stale accumulation.

Source files
------------

// File: rtl/mac_channel_acc.sv
// Sequential K x K multiply-accumulate across a runtime number of input channels,
// LANES products per beat, with bias preload on the first channel and optional ReLU.
module mac_channel_acc #(
  parameter int KERNEL_SIZE   = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 5,
  parameter int MAX_CHANNELS  = 16,
  localparam int NUM_PRODUCTS = KERNEL_SIZE * KERNEL_SIZE,
  localparam int ACC_WIDTH    = 2 * DATA_WIDTH + $clog2(NUM_PRODUCTS) + $clog2(MAX_CHANNELS),
  localparam int CH_W         = $clog2(MAX_CHANNELS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_WIDTH-1:0]   feature [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0]   kernel  [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
  input  logic        [CH_W-1:0]         num_channels,
  input  logic signed [2*DATA_WIDTH-1:0] bias,
  input  logic                           relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_WIDTH-1:0]    result
);

  localparam int BEATS  = (NUM_PRODUCTS + LANES - 1) / LANES;
  localparam int PAD_N  = BEATS * LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                        state_q;
  logic        [BEAT_W-1:0]      beat_q;
  logic        [CH_W-1:0]        ch_cnt_q;
  logic        [CH_W-1:0]        nch_q;
  logic                          relu_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [ACC_WIDTH-1:0]   acc_d;
  logic signed [ACC_WIDTH-1:0]   beat_sum;
  logic signed [ACC_WIDTH-1:0]   result_q;
  logic signed [DATA_WIDTH-1:0]  feat_q [0:PAD_N-1];
  logic signed [DATA_WIDTH-1:0]  kern_q [0:PAD_N-1];
  logic                          accept;
  logic                          last_beat;
  logic                          last_ch;

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PROD_W-1:0] v);
    return {{(ACC_WIDTH - PROD_W){v[PROD_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] relu_clamp(input logic signed [ACC_WIDTH-1:0] v,
                                                            input logic en);
    return (en && v[ACC_WIDTH-1]) ? '0 : v;
  endfunction

  function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] n);
    if (n == '0) return CH_W'(1);
    if (n > CH_W'(MAX_CHANNELS)) return CH_W'(MAX_CHANNELS);
    return n;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign accept    = in_valid && (state_q == S_IDLE);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign last_ch   = (ch_cnt_q == nch_q - CH_W'(1));

  // Beat stage: lanes always read the head of the shifting operand queue
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      beat_sum = beat_sum + sext_prod(PROD_W'(feat_q[l]) * PROD_W'(kern_q[l]));
    acc_d = acc_q + beat_sum;
  end

  // Operand queue: row-major load on accept, padding lanes zeroed, shift by LANES per beat
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          feat_q[i*KERNEL_SIZE + j] <= feature[i][j];
          kern_q[i*KERNEL_SIZE + j] <= kernel[i][j];
        end
      end
      for (int p = NUM_PRODUCTS; p < PAD_N; p++) begin
        feat_q[p] <= '0;
        kern_q[p] <= '0;
      end
    end else if (state_q == S_MAC) begin
      for (int p = 0; p < PAD_N - LANES; p++) begin
        feat_q[p] <= feat_q[p + LANES];
        kern_q[p] <= kern_q[p + LANES];
      end
    end
  end

  // Control and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      ch_cnt_q <= '0;
      nch_q    <= CH_W'(1);
      relu_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            beat_q  <= '0;
            state_q <= S_MAC;
            if (ch_cnt_q == '0) begin
              acc_q  <= sext_prod(bias);
              nch_q  <= clamp_ch(num_channels);
              relu_q <= relu_en;
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (last_beat) begin
            if (last_ch) begin
              result_q <= relu_clamp(acc_d, relu_q);
              state_q  <= S_DONE;
            end else begin
              ch_cnt_q <= ch_cnt_q + CH_W'(1);
              state_q  <= S_IDLE;
            end
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            ch_cnt_q <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_channel_acc.sv
// Randomized bench for mac_channel_acc: a dot-product reference model accumulates
// each accepted channel; handshake timing is checked cycle by cycle.
module tb_mac_channel_acc;

  localparam int K     = 5;
  localparam int DW    = 8;
  localparam int MAXC  = 16;
  localparam int ACCW  = 2*DW + 5 + 4;
  localparam int CHW   = 5;
  localparam int BEATS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic signed [DW-1:0]   feat_in [0:K-1][0:K-1];
  logic signed [DW-1:0]   kern_in [0:K-1][0:K-1];
  logic        [CHW-1:0]  num_channels = '0;
  logic signed [2*DW-1:0] bias = '0;
  logic                   relu_en = 1'b0;
  logic signed [ACCW-1:0] result, result4;

  int     n_checks = 0;
  int     n_errors = 0;
  longint model_acc;

  always #5 clk = ~clk;

  mac_channel_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .feature(feat_in), .kernel(kern_in), .num_channels(num_channels),
    .bias(bias), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  mac_channel_acc #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .feature(feat_in), .kernel(kern_in), .num_channels(num_channels),
    .bias(bias), .relu_en(relu_en), .out_valid(out_valid4),
    .out_ready(out_ready4), .result(result4)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit rnd, input int fv, input int kv);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        feat_in[i][j] = rnd ? DW'($urandom) : DW'(fv);
        kern_in[i][j] = rnd ? DW'($urandom) : DW'(kv);
      end
    end
  endtask

  function automatic longint dot();
    longint s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(feat_in[i][j]) * longint'(kern_in[i][j]);
    return s;
  endfunction

  task automatic accept_channel(input bit first, input int nreq, input int bias_v, input bit relu_v);
    if (first) begin
      num_channels = CHW'(nreq);
      bias         = (2*DW)'(bias_v);
      relu_en      = relu_v;
      model_acc    = bias_v;
    end else begin
      num_channels = CHW'($urandom);
      bias         = (2*DW)'($urandom);
      relu_en      = 1'($urandom);
    end
    check("idle_ready", in_ready, 1);
    model_acc += dot();
    in_valid = 1'b1;
    @(posedge clk); #1;
    fill(1, 0, 0);
    in_valid     = 1'($urandom);
    num_channels = CHW'($urandom);
    bias         = (2*DW)'($urandom);
    relu_en      = 1'($urandom);
  endtask

  task automatic wait_mac(input bit is_last, input string tag);
    int busy = 0;
    for (int c = 0; c < BEATS; c++) begin
      busy += int'(in_ready || out_valid);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready_after"}, in_ready, !is_last);
    check({tag, "_valid_after"}, out_valid, is_last);
  endtask

  task automatic run_op(input string tag, input int nreq, input int bias_v, input bit relu_v,
                        input bit rnd, input int fv, input int kv, input int hold,
                        input bit use_lit, input longint lit);
    int n;
    longint expv;
    logic signed [ACCW-1:0] held;
    n = (nreq == 0) ? 1 : ((nreq > MAXC) ? MAXC : nreq);
    for (int ch = 0; ch < n; ch++) begin
      fill(rnd, fv, kv);
      accept_channel(ch == 0, nreq, bias_v, relu_v);
      wait_mac(ch == n - 1, tag);
    end
    expv = (relu_v && model_acc < 0) ? 0 : model_acc;
    if (use_lit) expv = lit;
    check({tag, "_result"}, result, expv);
    held = result;
    for (int c = 0; c < hold; c++) begin
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, "_hold"}, {out_valid, in_ready, result == held}, 3'b101);
    end
    in_valid  = (hold > 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_release"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int lat;
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst4_in_ready", in_ready4, 1);

    run_op("ones", 1, 0, 0, 0, 1, 1, 0, 1, 25);
    run_op("ext_neg", 1, 0, 0, 0, -128, -128, 0, 1, 409600);
    run_op("ext_pos", 1, 0, 0, 0, -128, 127, 0, 1, -406400);
    run_op("multi", 3, -50, 0, 0, 2, 3, 0, 1, 400);

    // Abandon a 3-channel run at beat 2 of channel 1
    fill(0, 1, 1);
    accept_channel(1, 3, 0, 0);
    wait_mac(0, "rmid_ch0");
    fill(0, 1, 1);
    accept_channel(0, 3, 0, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rmid_in_ready", in_ready, 1);
    check("rmid_out_valid", out_valid, 0);
    check("rmid_result", result, 0);
    run_op("post_rst", 1, 0, 0, 0, 1, 1, 0, 1, 25);

    run_op("relu_off", 1, 0, 0, 0, 1, -1, 0, 1, -25);
    run_op("relu_on", 1, 0, 1, 0, 1, -1, 0, 1, 0);
    run_op("nch_zero", 0, 0, 0, 0, 1, 1, 0, 1, 25);
    run_op("nch_clamp", 31, 1000, 0, 1, 0, 0, 0, 0, 0);
    run_op("backpress", 2, 7, 0, 1, 0, 0, 10, 0, 0);

    for (int it = 0; it < 15; it++) begin
      run_op("rand", int'($urandom_range(4, 1)), int'($urandom_range(65535, 0)) - 32768,
             1'($urandom), 1, 0, 0, int'($urandom_range(2, 0)), 0, 0);
    end

    fill(0, 1, 1);
    num_channels = CHW'(1);
    bias         = '0;
    relu_en      = 1'b0;
    in_valid4    = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    fill(1, 0, 0);
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("l4_latency", lat, 7);
    check("l4_result", result4, 25);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("l4_release", in_ready4, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
